// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART with level interrupt on the CS_N/RD_N/WR_N data bus.
// Define UART_RX_FIFO_EN for an 8-entry receive FIFO; otherwise a single holding register.
module uart_bus_slave #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic        WR_N,
  input  logic [11:0] Addr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Intr,
  output logic        UART_TXD,
  input  logic        UART_RXD
);

  localparam int unsigned Div  = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] DivLast  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(Div / 2 - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  logic unused_bits;
  assign unused_bits = ^{Addr[11:4], Addr[1:0], DataIn[31:8]};

  logic       bus_wr;
  logic [1:0] reg_sel;
  logic       wr_tx, wr_rx, wr_stat, wr_ctrl;
  assign bus_wr  = !CS_N && !WR_N;
  assign reg_sel = Addr[3:2];
  assign wr_tx   = bus_wr && (reg_sel == 2'd0);
  assign wr_rx   = bus_wr && (reg_sel == 2'd1);
  assign wr_stat = bus_wr && (reg_sel == 2'd2);
  assign wr_ctrl = bus_wr && (reg_sel == 2'd3);

  // Transmitter
  uart_st_e        tx_state_q;
  logic [CntW-1:0] tx_cnt_q;
  logic [2:0]      tx_idx_q;
  logic [7:0]      tx_shift_q;
  logic            txd_q;
  logic            tx_ready;
  assign tx_ready = (tx_state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        StIdle: if (wr_tx) begin
          tx_state_q <= StStart;
          tx_cnt_q   <= '0;
          tx_shift_q <= DataIn[7:0];
          txd_q      <= 1'b0;
        end
        StStart: if (tx_cnt_q == DivLast) begin
          tx_cnt_q   <= '0;
          tx_idx_q   <= '0;
          tx_state_q <= StData;
          txd_q      <= tx_shift_q[0];
          tx_shift_q <= {1'b0, tx_shift_q[7:1]};
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        StData: if (tx_cnt_q == DivLast) begin
          tx_cnt_q <= '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_q <= StStop;
            txd_q      <= 1'b1;
          end else begin
            tx_idx_q   <= tx_idx_q + 1'b1;
            txd_q      <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        StStop: if (tx_cnt_q == DivLast) begin
          tx_cnt_q   <= '0;
          tx_state_q <= StIdle;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  // Receiver: the line is sampled mid-bit, DIV/2 after the synchronized falling edge
  logic            rxd_meta_q, rxd_sync_q;
  uart_st_e        rx_state_q;
  logic [CntW-1:0] rx_cnt_q;
  logic [2:0]      rx_idx_q;
  logic [7:0]      rx_shift_q;
  logic            rx_push_q, rx_ferr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_meta_q <= UART_RXD;
      rxd_sync_q <= rxd_meta_q;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        StIdle: if (!rxd_sync_q) begin
          rx_state_q <= StStart;
          rx_cnt_q   <= '0;
        end
        StStart: if (rx_cnt_q == HalfLast) begin
          rx_cnt_q   <= '0;
          rx_idx_q   <= '0;
          rx_state_q <= rxd_sync_q ? StIdle : StData;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        StData: if (rx_cnt_q == DivLast) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rxd_sync_q, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_q <= StStop;
          else rx_idx_q <= rx_idx_q + 1'b1;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        StStop: if (rx_cnt_q == DivLast) begin
          rx_cnt_q   <= '0;
          rx_state_q <= StIdle;
          rx_push_q  <= rxd_sync_q;
          rx_ferr_q  <= !rxd_sync_q;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: rx_state_q <= StIdle;
      endcase
    end
  end

  // Receive buffer; a pop frees the slot for a same-cycle push even when full
  logic       rx_valid, rx_full, do_pop, do_push, overrun_set;
  logic [7:0] rx_head;
  assign do_pop      = wr_rx && rx_valid;
  assign do_push     = rx_push_q && (!rx_full || do_pop);
  assign overrun_set = rx_push_q && rx_full && !do_pop;

`ifdef UART_RX_FIFO_EN
  logic [7:0] fifo_q [8];
  logic [2:0] rd_ptr_q, wr_ptr_q;
  logic [3:0] count_q;
  assign rx_valid = (count_q != 4'd0);
  assign rx_full  = (count_q == 4'd8);
  assign rx_head  = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {3'b0, do_push} - {3'b0, do_pop};
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_valid_q;
  assign rx_valid = hold_valid_q;
  assign rx_full  = hold_valid_q;
  assign rx_head  = hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else if (do_push) begin
      hold_q       <= rx_shift_q;
      hold_valid_q <= 1'b1;
    end else if (do_pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // Sticky flags, control and interrupt; a hardware set beats a same-cycle W1C
  logic overrun_q, frame_err_q, rx_ie_q, tx_ie_q, intr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_ie_q     <= 1'b0;
      tx_ie_q     <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      overrun_q   <= overrun_set || (overrun_q && !(wr_stat && DataIn[3]));
      frame_err_q <= rx_ferr_q || (frame_err_q && !(wr_stat && DataIn[4]));
      if (wr_ctrl) begin
        rx_ie_q <= DataIn[0];
        tx_ie_q <= DataIn[1];
      end
      intr_q <= (rx_ie_q && rx_valid) || (tx_ie_q && tx_ready);
    end
  end

  always_comb begin
    DataOut = '0;
    if (!CS_N && !RD_N) begin
      case (reg_sel)
        2'd1:    DataOut = {24'b0, rx_head};
        2'd2:    DataOut = {27'b0, frame_err_q, overrun_q, rx_full, rx_valid, tx_ready};
        2'd3:    DataOut = {30'b0, tx_ie_q, rx_ie_q};
        default: DataOut = '0;
      endcase
    end
  end

  assign UART_TXD = txd_q;
  assign Intr     = intr_q;

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed self-checking bench for uart_bus_slave at DIV = 16 (CLOCK_FREQ 16, BAUD_RATE 1).
module tb_uart_bus_slave;

  localparam int unsigned Div = 16;
  localparam logic [11:0] ATx = 12'h0, ARx = 12'h4, AStat = 12'h8, ACtrl = 12'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        CS_N, RD_N, WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn, DataOut;
  logic        Intr, UART_TXD, UART_RXD;
  logic        rxd_drv, loopback;

  int checks = 0;
  int errors = 0;

  assign UART_RXD = loopback ? UART_TXD : rxd_drv;

  always #5 clk = ~clk;

  uart_bus_slave #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .CS_N    (CS_N),
    .RD_N    (RD_N),
    .WR_N    (WR_N),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Intr    (Intr),
    .UART_TXD(UART_TXD),
    .UART_RXD(UART_RXD)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    CS_N = 1'b0; WR_N = 1'b0; Addr = a; DataIn = d;
    @(negedge clk);
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge clk);
    CS_N = 1'b0; RD_N = 1'b0; Addr = a;
    #1 d = DataOut;
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic drive_bit(input logic val, input int n);
    @(negedge clk);
    rxd_drv = val;
    repeat (n - 1) @(negedge clk);
  endtask

  // A bad stop bit is held only briefly so the line is high again before a re-start is confirmed
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0, Div);
    for (int i = 0; i < 8; i++) drive_bit(b[i], Div);
    if (stop_bit) drive_bit(1'b1, Div);
    else drive_bit(1'b0, Div / 2 + 2);
    drive_bit(1'b1, Div);
  endtask

  task automatic wait_rx_valid(output logic ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      bus_read(AStat, d);
      ok = d[1];
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        ok;
    logic [9:0]  frame;
    logic [1:0]  exp_full_valid;

    reset = 1'b1; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    Addr = '0; DataIn = '0; rxd_drv = 1'b1; loopback = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_txd", UART_TXD, 1);
    check("reset_intr", Intr, 0);
    check("dataout_unselected", DataOut, 0);
    bus_read(AStat, d); check("reset_status", d, 32'h1);
    bus_read(ACtrl, d); check("reset_ctrl", d, 32'h0);
    bus_read(ATx, d);   check("txdata_reads_zero", d, 32'h0);

    // TX 0x55; j counts cycles after the sampling edge of the write
    frame = {1'b1, 8'h55, 1'b0};
    bus_write(ATx, 32'h55);
    for (int j = 0; j < 176; j++) begin
      if (j < 160 && (j % 16 == 0 || j % 16 == 15))
        check($sformatf("tx_slot%0d_c%0d", j / 16, j), UART_TXD, frame[j / 16]);
      if (j == 20) begin CS_N = 1'b0; WR_N = 1'b0; Addr = ATx; DataIn = 32'hAA; end
      if (j == 21) begin CS_N = 1'b1; WR_N = 1'b1; end
      if (j == 159 || j == 160) begin
        CS_N = 1'b0; RD_N = 1'b0; Addr = AStat;
        #1 check($sformatf("tx_ready_c%0d", j), DataOut[0], (j == 160) ? 1 : 0);
        CS_N = 1'b1; RD_N = 1'b1;
      end
      if (j == 175) check("tx_busy_write_dropped", UART_TXD, 1);
      @(negedge clk);
    end

`ifdef UART_RX_FIFO_EN
    exp_full_valid = 2'b01;
`else
    exp_full_valid = 2'b11;
`endif

    // Loopback 0xA5
    loopback = 1'b1;
    bus_write(ATx, 32'hA5);
    wait_rx_valid(ok);
    check("loop_rx_valid_seen", ok, 1);
    bus_read(ARx, d);   check("loop_rxdata", d, 32'hA5);
    bus_read(AStat, d); check("loop_full_valid", d[2:1], exp_full_valid);
    bus_write(ARx, 32'h0);
    bus_read(AStat, d); check("loop_pop_clears_valid", d[1], 0);
    repeat (40) @(negedge clk);
    loopback = 1'b0;

    // 3-cycle glitch must not start a frame
    @(negedge clk); rxd_drv = 1'b0;
    repeat (3) @(negedge clk); rxd_drv = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(AStat, d); check("glitch_no_byte", d[4:1], 4'b0000);

    // Framing error
    send_frame(8'h3C, 1'b0);
    repeat (40) @(negedge clk);
    bus_read(AStat, d);
    check("ferr_set", d[4], 1);
    check("ferr_no_byte", d[1], 0);
    bus_write(AStat, 32'h10);
    bus_read(AStat, d); check("ferr_w1c", d[4], 0);

    // Overrun
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    repeat (8) @(negedge clk);
    bus_read(AStat, d); check("ovr_flags", d[3:1], 3'b111);
    for (int i = 1; i <= 8; i++) begin
      bus_read(ARx, d); check($sformatf("fifo_rd%0d", i), d, 32'(i));
      bus_write(ARx, 32'h0);
    end
`else
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    repeat (8) @(negedge clk);
    bus_read(AStat, d); check("ovr_flags", d[3:1], 3'b111);
    bus_read(ARx, d);   check("ovr_first_kept", d, 32'h01);
    bus_write(ARx, 32'h0);
`endif
    bus_read(AStat, d); check("ovr_drained", d[1], 0);
    bus_write(AStat, 32'h08);
    bus_read(AStat, d); check("ovr_w1c", d[3], 0);

    // Interrupt on receive, lagging rx_valid by one cycle
    bus_write(ACtrl, 32'h1);
    bus_read(ACtrl, d); check("ctrl_readback", d, 32'h1);
    check("intr_idle_empty", Intr, 0);
    fork
      send_frame(8'h77, 1'b1);
      begin
        wait_rx_valid(ok);
        check("intr_rx_seen", ok, 1);
        check("intr_lag", Intr, 0);
        @(negedge clk);
        check("intr_rx", Intr, 1);
      end
    join
    bus_read(ARx, d); check("intr_rxdata", d, 32'h77);
    bus_write(ARx, 32'h0);
    bus_write(ACtrl, 32'h2);
    check("intr_tx_lag", Intr, 0);
    @(negedge clk);
    check("intr_tx_ready", Intr, 1);
    bus_write(ACtrl, 32'h1);

    // Reset mid-frame
    bus_write(ATx, 32'h00);
    repeat (20) @(negedge clk);
    check("mid_frame_low", UART_TXD, 0);
    reset = 1'b1;
    @(posedge clk);
    #1 check("reset_abort_txd", UART_TXD, 1);
    @(negedge clk);
    reset = 1'b0;
    bus_read(AStat, d); check("post_reset_status", d, 32'h1);
    bus_read(ACtrl, d); check("post_reset_ctrl", d, 32'h0);
    check("post_reset_intr", Intr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 0x1 expected 0x0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_bus_slave.md
# uart_bus_slave

Memory-mapped UART peripheral that responds to RV32I CPU data-bus accesses and drives/receives the board serial pins `UART_TXD`/`UART_RXD`. It sits beside the timer and GPIO responders, selected by the address decoder's `CS_UART_N` chip select, and uses the same CS_N/RD_N/WR_N/Addr/DataIn/DataOut/Intr bus contract. It provides an 8N1 transmitter, an 8N1 receiver with a receive buffer, status and error flags, and a level interrupt.

## Interface
Parameters:
- `CLOCK_FREQ`, 125_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, 115_200: line rate. `DIV = CLOCK_FREQ / BAUD_RATE`, integer truncation (1085 at defaults). `DIV` must be ≥ 4.

Ports:
- `clk`, in, 1: the single clock. Everything is posedge.
- `reset`, in, 1: synchronous, active-high.
- `CS_N`, in, 1: chip select, active low.
- `RD_N`, in, 1: read strobe, active low.
- `WR_N`, in, 1: write strobe, active low.
- `Addr`, in, 12: byte address. Only `Addr[3:2]` is decoded; all other bits are ignored.
- `DataIn`, in, 32: write data.
- `DataOut`, out, 32: read data.
- `Intr`, out, 1: level interrupt, registered.
- `UART_TXD`, out, 1: serial out. Idles at 1.
- `UART_RXD`, in, 1: serial in. Asynchronous; passes through a 2-flop synchronizer.

## Operation
Register map:
- `0x0 TXDATA` (W): `DataIn[7:0]` starts a frame if the transmitter is idle. Writes while busy are dropped and change no state. Reads return 0.
- `0x4 RXDATA` (R/W): a read returns `{24'b0, head byte}` and has no side effect. A write of any value pops one entry; a pop when empty is a no-op.
- `0x8 STATUS` (R/W1C) bits:
  - [0] `tx_ready`
  - [1] `rx_valid` (buffer not empty)
  - [2] `rx_full`
  - [3] `overrun` (sticky)
  - [4] `frame_err` (sticky)
  - Writing 1 to bit 3 or 4 clears that bit. All other bits are read-only.
- `0xC CTRL` (R/W) bits: [0] `rx_ie`, [1] `tx_ie`.

Bus rules:
- A write occurs on a posedge with `CS_N=0` and `WR_N=0`.
- `DataOut` is combinational. It equals the addressed register when `CS_N=0` and `RD_N=0`, and is 0 otherwise.
- Reads are side-effect-free, so repeated or speculative read cycles are safe.

TX FSM (`IDLE → START → DATA → STOP → IDLE`):
- Baud counter runs 0..DIV-1; bit index runs 0..7, LSB first.
- Each state holds its line level for exactly DIV cycles.
- `tx_ready = (state == IDLE)`.

RX FSM (`IDLE → START → DATA → STOP → IDLE`):
- `IDLE`: a synchronized 0 enters `START`.
- `START`: re-sample at DIV/2. If the line is 1, treat as a false start and return to `IDLE`.
- `DATA`: sample every DIV cycles, 8 bits, LSB first.
- `STOP`: sample after DIV cycles.
  - Stop bit = 1: push the byte.
  - Stop bit = 0: discard the byte and set `frame_err`.
- Push when the buffer is full: the byte is dropped and `overrun` is set.

Interrupt:
- `Intr` is registered from `(rx_ie & rx_valid) | (tx_ie & tx_ready)`.

Reset values:
- `UART_TXD` = 1, `DataOut` = 0 (not selected), `Intr` = 0.
- Both FSMs in `IDLE`, buffer empty, flags 0, `CTRL` = 0.
- Reset asserted mid-frame aborts the frame. `UART_TXD` returns to 1 on the next posedge.

Simultaneous events:
- Push and pop in the same cycle: occupancy is unchanged. When full, the push is accepted and `overrun` is not set.
- Hardware set and W1C of the same flag in the same cycle: set wins.

## Timing
- TXDATA write at posedge k: `UART_TXD` = 0 from posedge k+1.
  - Data bit i is driven from k+1+(i+1)·DIV.
  - Stop bit is driven from k+1+9·DIV.
  - `tx_ready` = 1 from k+1+10·DIV.
- RX latency:
  - 2-cycle synchronizer.
  - Byte pushed, and `rx_valid` = 1, 1 cycle after the stop-bit sample, i.e. about 9.5·DIV+3 cycles after the start-bit falling edge.
- `Intr` lags its condition by 1 cycle.
- Register writes take effect at the next posedge.

## Configuration
- `UART_RX_FIFO_EN` defined: the receive buffer is an 8-entry circular FIFO with 3-bit read/write pointers and a 4-bit count. It wraps at 8; full when count = 8.
- `UART_RX_FIFO_EN` undefined: the receive buffer is a single holding register (full = valid). The register map and flags are identical.

## Test plan
- Reset: after `reset`, check `UART_TXD`=1, `Intr`=0, `STATUS`=0x1, `CTRL`=0.
- TX (`CLOCK_FREQ`=16, `BAUD_RATE`=1, so DIV=16): write 0x55 → line is 0, 1,0,1,0,1,0,1,0, 1, each level held 16 cycles. A second write of 0xAA during the frame is ignored. `tx_ready` rises at cycle k+161.
- RX with loopback of TXD into RXD: send 0xA5 → `rx_valid`=1 and `RXDATA`=0xA5. A write to `RXDATA` clears `rx_valid`.
- Glitch and framing: a 3-cycle low pulse on RXD produces no byte. A frame 0x3C with stop bit 0 → `frame_err`=1 and no byte pushed. W1C 0x10 clears `frame_err`.
- Overrun:
  - With the FIFO: send 9 bytes 0x01..0x09 → `rx_full`=1, `overrun`=1, and reads yield 0x01..0x08.
  - Without the FIFO: 2 bytes → 0x01 retained, `overrun`=1.
- Interrupt and reset: `CTRL`=0x1 with a byte received → `Intr`=1 one cycle after `rx_valid`. Asserting `reset` mid-TX frame → `UART_TXD`=1 next cycle.
